wc_z_serializer: RTL and testbench
==================================

Name: wc_z_serializer

Overview:
- Consumer-side block for the Winograd convolution core `wc`; sits directly downstream of it.
- Captures each packed result tile Z (N samples of W bits, as produced by `wc`) and buffers up to two tiles.
- Streams the tile out one sample per cycle over a valid/ready interface, with row-boundary marking.
- Detects and flags tiles lost to buffer overflow.

Parameters:
- N, 4, samples per result tile (Z width = N*W)
- W, 10, bits per signed sample
- TILES, 2, tiles per output row; sets s_last and the tile_cnt wrap point (TILES >= 1)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- z_in  input  N*W  packed tile; sample 0 in bits [N*W-1 -: W], sample N-1 in bits [W-1:0]
- z_valid  input  1  z_in valid this cycle
- z_ready  output  1  tile will be accepted this cycle (combinational)
- s_data  output  W  current output sample, two's complement, passed through unmodified
- s_valid  output  1  s_data valid
- s_ready  input  1  downstream accepts s_data
- s_last  output  1  last sample of last tile in row
- tile_cnt  output  clog2(TILES) (min 1)  index of tile at FIFO head within row
- ovf  output  1  sticky overflow flag

Behaviour:
- Storage: 2-entry FIFO of N*W-bit tiles, with write pointer, read pointer and count (0..2).
- Sample index idx runs 0..N-1 and selects the slice of the head tile.
- Reset (rst=0, async): count, pointers, idx, tile_cnt and ovf all go to 0 immediately. s_valid=0 and s_last=0. s_data=0, because the head entry is cleared.
- pop_tile = s_valid & s_ready & (idx==N-1).
- z_ready = (count<2) | pop_tile.
- push = z_valid & z_ready. On push, z_in is written at the clock edge.
- Latency: a tile pushed at edge k gives s_valid=1 after edge k when the FIFO was empty. Sample 0 appears in the cycle after the push.
- s_valid = (count!=0). s_data = head slice idx, driven combinationally from registered storage.
- While s_valid & !s_ready, s_data, s_last and tile_cnt hold stable.
- On s_valid & s_ready:
  - if idx<N-1, idx increments;
  - if idx==N-1, idx goes to 0, the head is popped, and tile_cnt increments, wrapping from TILES-1 to 0.
- s_last = s_valid & (idx==N-1) & (tile_cnt==TILES-1).
- Count update: count += push − pop_tile. A simultaneous push and pop_tile while full is legal and leaves count=2.
- Overflow: z_valid & !z_ready drops the tile, leaves all state unchanged, and sets ovf=1 at the next edge. ovf is cleared only by reset.
- Back-to-back tiles drain gaplessly: with s_ready held high and the FIFO non-empty, one sample per cycle with no bubble between tiles.
- Empty FIFO: s_ready is ignored and no state changes.
- Reset mid-tile: the partial tile and any buffered tile are discarded. The first tile after reset starts at sample 0 with tile_cnt=0.

Test Plan:
- Single tile (N=4, W=10, TILES=2):
  - stimulus: push z_in=0000001111_1101110101_1001011100_1010101000, s_ready=1;
  - required: one cycle after the push, s_data = 0x00F, 0x375, 0x25C, 0x2A8 (15, −139, −420, −344) on 4 consecutive cycles, then s_valid=0;
  - s_last=0 throughout, tile_cnt goes to 1 after the tile.
- Back-to-back:
  - stimulus: push the tile above, then push 1100100001_1011101011_1111000001_1111001111 on the next cycle, s_ready=1;
  - required: 8 contiguous samples 15, −139, −420, −344, −223, −277, −63, −49;
  - s_last=1 only on −49; tile_cnt wraps to 0; z_ready stays 1; ovf=0.
- Backpressure and overflow:
  - stimulus: push both tiles, drop s_ready after the first sample, then push a third tile while count=2;
  - required: s_data holds 0x375 while s_ready=0;
  - z_ready=0 and the third tile is dropped; ovf=1 and stays 1;
  - on resume, the stream continues −139, −420, −344, −223, … with no third tile.
- Simultaneous pop and push when full:
  - stimulus: count=2, idx=3, s_ready=1, and a third tile pushed in the same cycle;
  - required: z_ready=1, tile accepted, count stays 2, ovf=0;
  - third-tile samples follow the second tile.
- Reset mid-tile:
  - stimulus: assert rst=0 asynchronously between clock edges after sample 1 is accepted;
  - required: s_valid=0, s_last=0, ovf=0 immediately, with no clock edge;
  - after release and a new push, output restarts at sample 0 with tile_cnt=0.

Source files
------------

// File: rtl/wc_z_serializer.sv
// ---------------------------------------------------------------------------
// wc_z_serializer
//   Captures packed result tiles Z from the Winograd convolution core, buffers
//   up to two of them, and streams each tile out one signed sample per cycle
//   over a valid/ready interface. Row boundaries are marked with s_last, and
//   a sticky flag records any tile dropped because the buffer was full.
//
// Ports
//   clk       system clock, rising edge
//   rst       asynchronous reset, active low
//   z_in      packed tile, sample 0 in the top W bits, sample N-1 in [W-1:0]
//   z_valid   z_in valid this cycle
//   z_ready   tile is accepted this cycle (combinational)
//   s_data    current output sample, two's complement
//   s_valid   s_data valid
//   s_ready   downstream accepts s_data
//   s_last    last sample of the last tile in a row
//   tile_cnt  index within the row of the tile at the FIFO head
//   ovf       sticky overflow flag, cleared only by reset
// ---------------------------------------------------------------------------
module wc_z_serializer #(
    parameter int N     = 4,
    parameter int W     = 10,
    parameter int TILES = 2,
    localparam int TCW  = (TILES > 1) ? $clog2(TILES) : 1,
    localparam int IDXW = (N > 1) ? $clog2(N) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N*W-1:0]      z_in,
    input  logic                z_valid,
    output logic                z_ready,
    output logic signed [W-1:0] s_data,
    output logic                s_valid,
    input  logic                s_ready,
    output logic                s_last,
    output logic [TCW-1:0]      tile_cnt,
    output logic                ovf
);

    logic [N*W-1:0]  mem_q [2];
    logic [N*W-1:0]  mem_d [2];
    logic            wr_ptr_q, wr_ptr_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic [1:0]      count_q, count_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [TCW-1:0]  tile_cnt_q, tile_cnt_d;
    logic            ovf_q, ovf_d;

    logic            idx_end;
    logic            row_end;
    logic            beat;
    logic            pop_tile;
    logic            push;
    logic [N*W-1:0]  head;

    assign idx_end  = (idx_q == IDXW'(N - 1));
    assign row_end  = (tile_cnt_q == TCW'(TILES - 1));
    assign s_valid  = (count_q != 2'd0);
    assign beat     = s_valid & s_ready;
    assign pop_tile = beat & idx_end;
    // A pop of the last sample frees a slot in the same cycle, so a full
    // FIFO can still accept a tile while it drains.
    assign z_ready  = (count_q < 2'd2) | pop_tile;
    assign push     = z_valid & z_ready;
    assign s_last   = s_valid & idx_end & row_end;
    assign tile_cnt = tile_cnt_q;
    assign ovf      = ovf_q;
    assign head     = mem_q[rd_ptr_q];

    // Output stage: slice of the head tile selected by idx, sample 0 at the top
    always_comb begin : slice_sel
        s_data = '0;
        for (int i = 0; i < N; i++) begin
            if (idx_q == IDXW'(i)) begin
                s_data = $signed(head[(N-1-i)*W +: W]);
            end
        end
    end

    always_comb begin : next_state
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        idx_d      = idx_q;
        tile_cnt_d = tile_cnt_q;
        ovf_d      = ovf_q;

        if (push) begin
            mem_d[wr_ptr_q] = z_in;
            wr_ptr_d        = ~wr_ptr_q;
        end

        if (beat) begin
            if (idx_end) begin
                idx_d      = '0;
                rd_ptr_d   = ~rd_ptr_q;
                tile_cnt_d = row_end ? '0 : tile_cnt_q + 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end

        case ({push, pop_tile})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        // A refused tile is lost; nothing else changes.
        if (z_valid && !z_ready) begin
            ovf_d = 1'b1;
        end
    end

    // Register stage: storage is cleared too so s_data reads 0 out of reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            idx_q      <= '0;
            tile_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            mem_q[0]   <= mem_d[0];
            mem_q[1]   <= mem_d[1];
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            tile_cnt_q <= tile_cnt_d;
            ovf_q      <= ovf_d;
        end
    end

endmodule

// File: tb/tb_wc_z_serializer.sv
// ---------------------------------------------------------------------------
// tb_wc_z_serializer
//   Directed bench for wc_z_serializer. A sample-stream model (a queue of
//   expected samples annotated with row position) is checked against the DUT
//   on every falling edge; directed checks with literal values pin the model.
// ---------------------------------------------------------------------------
module tb_wc_z_serializer;

    localparam int N     = 4;
    localparam int W     = 10;
    localparam int TILES = 2;
    localparam int TCW   = 1;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [N*W-1:0]      z_in = '0;
    logic                z_valid = 1'b0;
    logic                z_ready;
    logic signed [W-1:0] s_data;
    logic                s_valid;
    logic                s_ready = 1'b0;
    logic                s_last;
    logic [TCW-1:0]      tile_cnt;
    logic                ovf;

    wc_z_serializer #(.N(N), .W(W), .TILES(TILES)) dut (
        .clk      (clk),
        .rst      (rst),
        .z_in     (z_in),
        .z_valid  (z_valid),
        .z_ready  (z_ready),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_last   (s_last),
        .tile_cnt (tile_cnt),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    localparam logic [N*W-1:0] T1 = {10'h00F, 10'h375, 10'h25C, 10'h2A8};
    localparam logic [N*W-1:0] T2 = {10'h321, 10'h2EB, 10'h3C1, 10'h3CF};
    localparam logic [N*W-1:0] T3 = {10'd1, 10'd2, 10'd3, 10'd4};

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    endtask

    // ---------------- model: expected output sample stream ----------------
    typedef struct {
        int data;
        bit last;
        int tc;
    } samp_t;

    samp_t q[$];
    int    seq  = 0;
    bit    movf = 1'b0;

    function automatic bit m_pop();
        return (q.size() != 0) && s_ready && ((q.size() % N) == 1);
    endfunction

    function automatic bit m_zready();
        int tiles_held;
        tiles_held = (q.size() + N - 1) / N;
        return (tiles_held < 2) || m_pop();
    endfunction

    initial begin : model
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                q.delete();
                seq  = 0;
                movf = 1'b0;
            end else begin
                bit zr;
                bit adv;
                zr  = m_zready();
                adv = (q.size() != 0) && s_ready;
                if (adv) void'(q.pop_front());
                if (z_valid && zr) begin
                    for (int i = 0; i < N; i++) begin
                        samp_t s;
                        logic [W-1:0] raw;
                        raw    = z_in[(N-1-i)*W +: W];
                        s.data = $signed(raw);
                        s.tc   = seq % TILES;
                        s.last = (i == N-1) && (s.tc == TILES-1);
                        q.push_back(s);
                    end
                    seq++;
                end
                if (z_valid && !zr) movf = 1'b1;
            end
        end
    end

    // Samples actually accepted from the DUT, for the directed checks.
    int out_d[$];
    bit out_l[$];

    initial begin : compare
        forever begin
            @(negedge clk);
            chk("s_valid", s_valid, q.size() != 0);
            if (q.size() != 0) begin
                chk("s_data", s_data, q[0].data);
                chk("s_last", s_last, q[0].last);
                chk("tile_cnt", tile_cnt, q[0].tc);
            end else begin
                chk("s_last_idle", s_last, 1'b0);
            end
            chk("z_ready", z_ready, m_zready());
            chk("ovf", ovf, movf);
            if (rst && s_valid && s_ready) begin
                out_d.push_back(s_data);
                out_l.push_back(s_last);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b0;
        z_valid = 1'b0;
        s_ready = 1'b0;
        step();
        step();
        rst = 1'b1;
        out_d.delete();
        out_l.delete();
    endtask

    task automatic chk_log(input string nm, input int exp[], input int lastpos);
        chk({nm, "_len"}, out_d.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            chk($sformatf("%s_d%0d", nm, i), (i < out_d.size()) ? out_d[i] : 32'hDEAD, exp[i]);
            chk($sformatf("%s_l%0d", nm, i), (i < out_l.size()) ? out_l[i] : 1'bx, i == lastpos);
        end
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, limit 100000 required");
        $fatal(1);
    end

    initial begin : stim
        int e1[]  = '{15, -139, -420, -344};
        int e2[]  = '{15, -139, -420, -344, -223, -277, -63, -49};
        int e4[]  = '{15, -139, -420, -344, -223, -277, -63, -49, 1, 2, 3, 4};
        int e5[]  = '{-223, -277, -63, -49};

        // Reset state
        #3;
        chk("rst_s_valid", s_valid, 1'b0);
        chk("rst_s_last", s_last, 1'b0);
        chk("rst_s_data", s_data, 0);
        chk("rst_tile_cnt", tile_cnt, 0);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_z_ready", z_ready, 1'b1);
        do_reset();

        // Single tile
        z_in = T1; z_valid = 1'b1; s_ready = 1'b1;
        step();
        z_valid = 1'b0;
        chk("t1_first_valid", s_valid, 1'b1);
        chk("t1_first_data", s_data, 15);
        repeat (5) step();
        chk_log("t1", e1, -1);
        chk("t1_tile_cnt", tile_cnt, 1);
        chk("t1_drained", s_valid, 1'b0);

        // Back-to-back tiles
        do_reset();
        z_in = T1; z_valid = 1'b1; s_ready = 1'b1;
        step();
        z_in = T2;
        step();
        z_valid = 1'b0;
        repeat (9) step();
        chk_log("b2b", e2, 7);
        chk("b2b_tile_cnt", tile_cnt, 0);
        chk("b2b_ovf", ovf, 1'b0);

        // Backpressure and overflow
        do_reset();
        z_in = T1; z_valid = 1'b1; s_ready = 1'b1;
        step();
        z_in = T2;
        step();
        s_ready = 1'b0; z_in = T3;
        #1;
        chk("bp_z_ready", z_ready, 1'b0);
        chk("bp_hold0", s_data, -139);
        step();
        z_valid = 1'b0;
        chk("bp_ovf_set", ovf, 1'b1);
        chk("bp_hold1", s_data, -139);
        repeat (3) step();
        chk("bp_hold2", s_data, -139);
        chk("bp_ovf_sticky", ovf, 1'b1);
        s_ready = 1'b1;
        repeat (8) step();
        chk_log("bp", e2, 7);
        chk("bp_drained", s_valid, 1'b0);
        chk("bp_ovf_end", ovf, 1'b1);

        // Simultaneous pop and push while full
        do_reset();
        z_in = T1; z_valid = 1'b1; s_ready = 1'b1;
        step();
        z_in = T2;
        step();
        z_valid = 1'b0;
        step();
        step();
        z_in = T3; z_valid = 1'b1;
        #1;
        chk("full_z_ready", z_ready, 1'b1);
        chk("full_last_smp", s_data, -344);
        step();
        z_valid = 1'b0;
        chk("full_ovf", ovf, 1'b0);
        chk("full_next", s_data, -223);
        repeat (10) step();
        chk_log("full", e4, 7);

        // Reset mid-tile, with ovf previously set
        do_reset();
        z_in = T1; z_valid = 1'b1;
        step();
        z_in = T2;
        step();
        z_in = T3;
        step();
        z_valid = 1'b0;
        chk("mr_ovf_pre", ovf, 1'b1);
        s_ready = 1'b1;
        step();
        step();
        chk("mr_mid", s_data, -420);
        #2;
        rst = 1'b0;
        #1;
        chk("mr_s_valid", s_valid, 1'b0);
        chk("mr_s_last", s_last, 1'b0);
        chk("mr_ovf", ovf, 1'b0);
        chk("mr_s_data", s_data, 0);
        chk("mr_tile_cnt", tile_cnt, 0);
        step();
        rst = 1'b1;
        out_d.delete();
        out_l.delete();
        z_in = T2; z_valid = 1'b1; s_ready = 1'b1;
        step();
        z_valid = 1'b0;
        chk("mr_restart", s_data, -223);
        chk("mr_restart_tc", tile_cnt, 0);
        repeat (5) step();
        chk_log("mr", e5, -1);
        chk("mr_tile_cnt_end", tile_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
